// File: rtl/avalon_copy_pkg.sv
// Shared types and constants for the Avalon-MM copy master.
package avalon_copy_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 10;
   localparam int LEN_W_DEF  = 11;
   localparam int BYTE_SHIFT = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      FINISH  = 3'd4
   } state_e;

endpackage

// File: rtl/avalon_copy_master.sv
// Avalon-MM master copying a block of words: one read, then its write, per word.
module avalon_copy_master
   import avalon_copy_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [LEN_W-1:0]      len,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [ADDR_W+1:0]     m_address,
   output logic                  m_read,
   output logic                  m_write,
   output logic [DATA_W/8-1:0]   m_byteenable,
   output logic [DATA_W-1:0]     m_writedata,
   input  logic [DATA_W-1:0]     m_readdata,
   input  logic                  m_waitrequest,
   input  logic                  m_readdatavalid
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, dst_q;
   logic [LEN_W-1:0]    rem_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                aborted_q;

   logic wr_acc;
   logic last_word;
   assign wr_acc    = (state_q == WR_REQ) && !m_waitrequest;
   assign last_word = (rem_q == LEN_W'(1));

   // Abort is only honoured at write acceptance, so a read in flight is always
   // completed and written back before stopping.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (len == '0) ? FINISH : RD_REQ;
         RD_REQ:  if (!m_waitrequest) state_d = RD_WAIT;
         RD_WAIT: if (m_readdatavalid) state_d = WR_REQ;
         WR_REQ:  if (!m_waitrequest) state_d = (last_word || abort) ? FINISH : RD_REQ;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         rem_q     <= '0;
         wdata_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            rem_q     <= len;
            aborted_q <= 1'b0;
         end
         if (state_q == RD_WAIT && m_readdatavalid)
            wdata_q <= m_readdata;
         // Addresses wrap naturally at 2^ADDR_W.
         if (wr_acc) begin
            rem_q <= rem_q - LEN_W'(1);
            src_q <= src_q + ADDR_W'(1);
            dst_q <= dst_q + ADDR_W'(1);
            if (abort && !last_word) aborted_q <= 1'b1;
         end
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == FINISH);
   assign aborted      = aborted_q;
   assign m_read       = (state_q == RD_REQ);
   assign m_write      = (state_q == WR_REQ);
   assign m_byteenable = m_write ? {(DATA_W/8){1'b1}} : '0;
   assign m_writedata  = wdata_q;

   always_comb begin
      m_address = '0;
      if (state_q == RD_REQ) m_address = {src_q, {BYTE_SHIFT{1'b0}}};
      if (state_q == WR_REQ) m_address = {dst_q, {BYTE_SHIFT{1'b0}}};
   end

endmodule

// File: tb/tb_avalon_copy_master.sv
// Directed bench for avalon_copy_master with a behavioural single-port RAM slave.
module tb_avalon_copy_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  src_addr = '0, dst_addr = '0;
   logic [10:0] len = '0;
   logic        abort = 1'b0;
   logic        busy, done, aborted;
   logic [11:0] m_address;
   logic        m_read, m_write;
   logic [3:0]  m_byteenable;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;
   logic        m_waitrequest;
   logic        m_readdatavalid;

   avalon_copy_master dut (
      .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy), .done(done),
      .aborted(aborted), .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_readdata(m_readdata),
      .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid)
   );

   always #5 clk = ~clk;

   // ---------------- RAM slave model ----------------
   logic [31:0] mem [0:1023];
   logic [11:0] rd_log[$];
   logic [11:0] wr_log[$];
   logic        force_wait = 1'b0;
   logic        rand_en = 1'b0;
   logic        preload_pulse = 1'b0;
   logic        rand_q;
   logic        hold_v;
   logic [49:0] hold_snap;
   int          stall_viol = 0;

   function automatic logic [31:0] init_val(input int i);
      if (i < 4) return 32'h11111111 * (i + 1);
      return 32'hC0DE0000 | 32'(i);
   endfunction

   assign m_waitrequest = force_wait | rand_q;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_readdatavalid <= 1'b0;
         m_readdata      <= '0;
         rand_q          <= 1'b0;
         hold_v          <= 1'b0;
         hold_snap       <= '0;
      end else begin
         m_readdatavalid <= 1'b0;
         if (preload_pulse) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            rd_log.delete();
            wr_log.delete();
         end else begin
            if (m_read && !m_waitrequest) begin
               m_readdatavalid <= 1'b1;
               m_readdata      <= mem[m_address[11:2]];
               rd_log.push_back(m_address);
            end
            if (m_write && !m_waitrequest) begin
               mem[m_address[11:2]] <= m_writedata;
               wr_log.push_back(m_address);
            end
         end
         if (hold_v && ({m_address, m_read, m_write, m_byteenable, m_writedata} != hold_snap))
            stall_viol <= stall_viol + 1;
         hold_v    <= (m_read || m_write) && m_waitrequest;
         hold_snap <= {m_address, m_read, m_write, m_byteenable, m_writedata};
         rand_q    <= rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic preload();
      @(negedge clk);
      preload_pulse = 1'b1;
      @(negedge clk);
      preload_pulse = 1'b0;
   endtask

   // Start cycle counts as cycle 1; returns the cycle in which done was seen (0 = timeout).
   task automatic kick(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                       output int done_cyc, output bit busy_ok);
      int cyc;
      @(negedge clk);
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      cyc = 1; done_cyc = 0; busy_ok = 1'b1;
      while (done_cyc == 0 && cyc < 3000) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (!busy) busy_ok = 1'b0;
         if (done) done_cyc = cyc;
      end
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (!done && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("done_reached", 64'(done), 64'd1);
   endtask

   typedef struct {
      logic [9:0]  src;
      logic [9:0]  dst;
      logic [10:0] len;
      bit          rnd;
      int          exp_cyc;   // 0 = not checked (random stalls)
   } vec_t;

   task automatic run_vec(input vec_t v, input string tag);
      int  dc;
      bit  bok;
      int  n;
      rand_en = v.rnd;
      preload();
      kick(v.src, v.dst, v.len, dc, bok);
      rand_en = 1'b0;
      n = int'(v.len);
      chk({tag, "_done_seen"}, 64'(dc != 0), 64'd1);
      if (v.exp_cyc != 0) chk({tag, "_done_cycle"}, 64'(dc), 64'(v.exp_cyc));
      chk({tag, "_busy_until_done"}, 64'(bok), 64'd1);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
      chk({tag, "_aborted"}, 64'(aborted), 64'd0);
      chk({tag, "_n_reads"}, 64'(rd_log.size()), 64'(n));
      chk({tag, "_n_writes"}, 64'(wr_log.size()), 64'(n));
      for (int k = 0; k < n && k < rd_log.size() && k < wr_log.size(); k++) begin
         logic [9:0] sw, dw;
         sw = v.src + 10'(k);
         dw = v.dst + 10'(k);
         chk($sformatf("%s_rd_addr%0d", tag, k), 64'(rd_log[k]), 64'({sw, 2'b00}));
         chk($sformatf("%s_wr_addr%0d", tag, k), 64'(wr_log[k]), 64'({dw, 2'b00}));
         chk($sformatf("%s_data%0d", tag, k), 64'(mem[dw]), 64'(init_val(int'(sw))));
      end
      begin
         logic [9:0] past;
         past = v.dst + 10'(n);
         chk({tag, "_past_end_untouched"}, 64'(mem[past]), 64'(init_val(int'(past))));
      end
   endtask

   vec_t vecs[5];

   initial begin
      int  dc;
      bit  bok;
      int  c;

      vecs[0] = '{src: 10'd0,    dst: 10'd100, len: 11'd4, rnd: 1'b0, exp_cyc: 14};
      vecs[1] = '{src: 10'd200,  dst: 10'd300, len: 11'd8, rnd: 1'b1, exp_cyc: 0};
      vecs[2] = '{src: 10'd1022, dst: 10'd10,  len: 11'd4, rnd: 1'b0, exp_cyc: 14};
      vecs[3] = '{src: 10'd5,    dst: 10'd50,  len: 11'd0, rnd: 1'b0, exp_cyc: 2};
      vecs[4] = '{src: 10'd500,  dst: 10'd600, len: 11'd3, rnd: 1'b1, exp_cyc: 0};

      // Reset state
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_aborted", 64'(aborted), 64'd0);
      chk("rst_rw", 64'({m_read, m_write}), 64'd0);
      chk("rst_addr", 64'(m_address), 64'd0);
      chk("rst_be_wd", 64'({m_byteenable, m_writedata}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Abort while idle has no effect
      abort = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_abort_busy", 64'(busy), 64'd0);
      chk("idle_abort_aborted", 64'(aborted), 64'd0);
      abort = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Abort while the 3rd read is stalled: that word still completes
      preload();
      @(negedge clk);
      src_addr = 10'd0; dst_addr = 10'd700; len = 11'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (!(wr_log.size() == 2 && m_read) && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("ab_reached_rd3", 64'(c < 200), 64'd1);
      force_wait = 1'b1;
      abort = 1'b1;
      repeat (3) @(negedge clk);
      chk("ab_rd3_held", 64'(m_read), 64'd1);
      force_wait = 1'b0;
      wait_done(100);
      @(negedge clk);
      chk("ab_n_reads", 64'(rd_log.size()), 64'd3);
      chk("ab_n_writes", 64'(wr_log.size()), 64'd3);
      chk("ab_aborted", 64'(aborted), 64'd1);
      chk("ab_word2", 64'(mem[702]), 64'(init_val(2)));
      chk("ab_word3_untouched", 64'(mem[703]), 64'(init_val(703)));
      abort = 1'b0;
      kick(10'd0, 10'd900, 11'd1, dc, bok);
      chk("ab_restart_done", 64'(dc), 64'd5);
      chk("ab_restart_clears", 64'(aborted), 64'd0);

      // Start and abort together: start taken, stop after first word
      preload();
      abort = 1'b1;
      kick(10'd0, 10'd800, 11'd4, dc, bok);
      abort = 1'b0;
      @(negedge clk);
      chk("sa_n_writes", 64'(wr_log.size()), 64'd1);
      chk("sa_aborted", 64'(aborted), 64'd1);

      // Start while busy is ignored
      preload();
      @(negedge clk);
      src_addr = 10'd0; dst_addr = 10'd400; len = 11'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      src_addr = 10'd50; dst_addr = 10'd450; len = 11'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(100);
      @(negedge clk);
      chk("sb_n_writes", 64'(wr_log.size()), 64'd2);
      chk("sb_word1", 64'(mem[401]), 64'(init_val(1)));
      chk("sb_other_untouched", 64'(mem[450]), 64'(init_val(450)));

      // Async reset while a write is stalled
      preload();
      @(negedge clk);
      src_addr = 10'd20; dst_addr = 10'd40; len = 11'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (!m_write && c < 50) begin
         @(negedge clk);
         c++;
      end
      force_wait = 1'b1;
      @(negedge clk);
      chk("rs_in_write", 64'(m_write), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rs_write_drop", 64'(m_write), 64'd0);
      chk("rs_busy_drop", 64'(busy), 64'd0);
      chk("rs_addr_be", 64'({m_address, m_byteenable}), 64'd0);
      repeat (2) @(negedge clk);
      force_wait = 1'b0;
      reset_n = 1'b1;
      run_vec(vecs[0], "post_rst");

      chk("stall_stability", 64'(stall_viol), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
